// File: rtl/aes_mix_columns_seq.sv
// aes_mix_columns_seq: sequential AES MixColumns / InvMixColumns over a
// 128-bit state, COLS_PER_CYCLE columns per clock, valid/ready on both sides.
module aes_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inValid,
  output logic         inReady,
  input  logic [127:0] inData,
  input  logic         inInverse,
  output logic         outValid,
  input  logic         outReady,
  output logic [127:0] outData,
  output logic         busy
);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
      $error("aes_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_reg, state_next;
  logic [127:0] work_reg, work_next;
  logic [2:0]   col_cnt_reg;
  logic         mode_reg;
  logic [127:0] out_data_reg;
  logic         out_valid_reg;
  logic         last_step;

  // GF(2^8) multiply by x, reduction polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One column: forward uses {02,03,01,01}, inverse {0E,0B,0D,09}.
  // The inverse path builds 2a, 4a, 8a once per byte and reuses them.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a  [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] b  [4];
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      m2[r] = xtime(a[r]);
      m4[r] = xtime(m2[r]);
      m8[r] = xtime(m4[r]);
      m9[r] = m8[r] ^ a[r];
      mb[r] = m8[r] ^ m2[r] ^ a[r];
      md[r] = m8[r] ^ m4[r] ^ a[r];
      me[r] = m8[r] ^ m4[r] ^ m2[r];
    end
    for (int r = 0; r < 4; r++) begin
      if (inv)
        b[r] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
      else
        b[r] = m2[r] ^ m2[(r+1)%4] ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  // Column view of the work register.
  logic [31:0] cols      [4];
  logic [31:0] cols_next [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cols
      assign cols[gi] = work_reg[127-32*gi -: 32];
    end
  endgenerate

  // One mixing unit per column slot; slot gi handles column col_cnt+gi.
  logic [1:0]  slot_idx [COLS_PER_CYCLE];
  logic [31:0] slot_out [COLS_PER_CYCLE];

  generate
    for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_slots
      assign slot_idx[gi] = col_cnt_reg[1:0] + 2'(gi);
      assign slot_out[gi] = mix_col(cols[slot_idx[gi]], mode_reg);
    end
  endgenerate

  // Write transformed columns back in place; untouched columns pass through.
  always_comb begin
    cols_next = cols;
    for (int s = 0; s < COLS_PER_CYCLE; s++) begin
      cols_next[slot_idx[s]] = slot_out[s];
    end
    work_next = {cols_next[0], cols_next[1], cols_next[2], cols_next[3]};
  end

  assign last_step = ({1'b0, col_cnt_reg} + 4'(COLS_PER_CYCLE)) == 4'd4;

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (inValid)   state_next = BUSY;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    if (outReady)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch on accept, mix columns while busy, register the result.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      work_reg      <= '0;
      col_cnt_reg   <= '0;
      mode_reg      <= 1'b0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (inValid) begin
            work_reg    <= inData;
            mode_reg    <= inInverse;
            col_cnt_reg <= '0;
          end
        end
        BUSY: begin
          work_reg    <= work_next;
          col_cnt_reg <= col_cnt_reg + 3'(COLS_PER_CYCLE);
          if (last_step) begin
            out_data_reg  <= work_next;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (outReady) out_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign inReady  = (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);
  assign outValid = out_valid_reg;
  assign outData  = out_data_reg;

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// Scoreboard bench: three DUTs (COLS_PER_CYCLE = 1, 2, 4) fed the same blocks.
module tb_aes_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rstn;
  logic [127:0] in_data;
  logic         in_inverse;
  logic         in_valid  [3];
  logic         out_ready [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic [127:0] out_data  [3];
  logic         busy      [3];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode = 0;

  logic [127:0] q0[$];
  logic [127:0] q1[$];
  logic [127:0] q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic inv);
    logic [7:0]   k [4];
    logic [7:0]   a [4];
    logic [7:0]   b;
    logic [127:0] r = '0;
    if (inv) k = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     k = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127-8*(4*c+j) -: 8];
      for (int j = 0; j < 4; j++) begin
        b = 8'h00;
        for (int t = 0; t < 4; t++) b = b ^ gmul(k[t], a[(j+t)%4]);
        r[127-8*(4*c+j) -: 8] = b;
      end
    end
    return r;
  endfunction

  task automatic push_exp(input logic [127:0] e);
    q0.push_back(e);
    q1.push_back(e);
    q2.push_back(e);
  endtask

  task automatic check_out(input int lane, input logic [127:0] got);
    logic [127:0] e = '0;
    logic         have = 1'b0;
    if (lane == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
    if (lane == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
    if (lane == 2 && q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    n_vec++;
    if (!have) begin
      n_err++;
      $display("FAIL lane%0d unexpected_output: got %h want <none>", lane, got);
    end else if (got !== e) begin
      n_err++;
      $display("FAIL lane%0d out_data: got %h want %h", lane, got, e);
    end else begin
      $display("lane%0d ok %h", lane, got);
    end
  endtask

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      localparam int CPC = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
      localparam int LAT = 4 / CPC;
      int   acc_cyc = 0;
      logic prev_valid = 1'b0;

      aes_mix_columns_seq #(.COLS_PER_CYCLE(CPC)) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .inValid   (in_valid[gi]),
        .inReady   (in_ready[gi]),
        .inData    (in_data),
        .inInverse (in_inverse),
        .outValid  (out_valid[gi]),
        .outReady  (out_ready[gi]),
        .outData   (out_data[gi]),
        .busy      (busy[gi])
      );

      // Monitor: latency on outValid rise, data on each output transfer.
      always @(negedge clk) begin
        if (out_valid[gi] && !prev_valid) begin
          n_vec++;
          if (cyc - acc_cyc != LAT) begin
            n_err++;
            $display("FAIL lane%0d latency: got %0d want %0d", gi, cyc - acc_cyc, LAT);
          end
        end
        if (rstn && out_valid[gi] && out_ready[gi]) check_out(gi, out_data[gi]);
        if (rstn && in_valid[gi] && in_ready[gi]) acc_cyc = cyc + 1;
        prev_valid = out_valid[gi];
      end

      // Random downstream throttling when enabled.
      always @(posedge clk) begin
        if (rdy_mode == 1) begin
          #1;
          out_ready[gi] = 1'($urandom_range(0, 1));
        end
      end
    end
  endgenerate

  // Present one block to all lanes; each lane drops inValid on its accept.
  task automatic send(input logic [127:0] d, input logic inv, input logic [127:0] e, input int gap);
    logic acc [3];
    int   waited = 0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    in_data    = d;
    in_inverse = inv;
    for (int l = 0; l < 3; l++) in_valid[l] = 1'b1;
    push_exp(e);
    forever begin
      @(negedge clk);
      for (int l = 0; l < 3; l++) acc[l] = in_valid[l] && in_ready[l];
      @(posedge clk);
      #1;
      for (int l = 0; l < 3; l++) if (acc[l]) in_valid[l] = 1'b0;
      if (!in_valid[0] && !in_valid[1] && !in_valid[2]) break;
      waited++;
      if (waited > 200) begin
        n_err++;
        $display("FAIL accept_timeout: got no accept want accept");
        for (int l = 0; l < 3; l++) in_valid[l] = 1'b0;
        break;
      end
    end
    in_data    = {$urandom, $urandom, $urandom, $urandom};
    in_inverse = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && w < 500) begin
      @(posedge clk);
      w++;
    end
    #1;
    n_vec++;
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", q0.size() + q1.size() + q2.size());
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] snap [3];
    logic [127:0] x, y;
    logic         inv;
    int           w;

    rstn = 1'b0;
    in_data = '0;
    in_inverse = 1'b0;
    for (int l = 0; l < 3; l++) begin in_valid[l] = 1'b0; out_ready[l] = 1'b1; end
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Reset state.
    @(negedge clk);
    for (int l = 0; l < 3; l++) begin
      n_vec += 4;
      if (in_ready[l] !== 1'b1) begin n_err++; $display("FAIL lane%0d reset_inReady: got %b want 1", l, in_ready[l]); end
      if (out_valid[l] !== 1'b0) begin n_err++; $display("FAIL lane%0d reset_outValid: got %b want 0", l, out_valid[l]); end
      if (out_data[l] !== '0) begin n_err++; $display("FAIL lane%0d reset_outData: got %h want 0", l, out_data[l]); end
      if (busy[l] !== 1'b0) begin n_err++; $display("FAIL lane%0d reset_busy: got %b want 0", l, busy[l]); end
    end
    @(posedge clk);
    #1;

    // Directed vectors.
    send(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 0);
    send(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 0);
    send(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0, 128'h046681e5_e0cb199a_48f8d37a_2806264c, 0);
    send(128'h046681e5_e0cb199a_48f8d37a_2806264c, 1'b1, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 0);
    wait_drain();

    // Backpressure: hold DONE for 10 cycles with inValid offered.
    for (int l = 0; l < 3; l++) out_ready[l] = 1'b0;
    send(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0, 128'h046681e5_e0cb199a_48f8d37a_2806264c, 0);
    w = 0;
    do begin @(negedge clk); w++; end
    while (!(out_valid[0] && out_valid[1] && out_valid[2]) && w < 50);
    for (int l = 0; l < 3; l++) snap[l] = out_data[l];
    @(posedge clk);
    #1;
    for (int l = 0; l < 3; l++) in_valid[l] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      for (int l = 0; l < 3; l++) begin
        n_vec += 3;
        if (out_valid[l] !== 1'b1) begin n_err++; $display("FAIL lane%0d hold_outValid: got %b want 1", l, out_valid[l]); end
        if (out_data[l] !== snap[l]) begin n_err++; $display("FAIL lane%0d hold_outData: got %h want %h", l, out_data[l], snap[l]); end
        if (in_ready[l] !== 1'b0) begin n_err++; $display("FAIL lane%0d hold_inReady: got %b want 0", l, in_ready[l]); end
      end
    end
    @(posedge clk);
    #1;
    for (int l = 0; l < 3; l++) begin in_valid[l] = 1'b0; out_ready[l] = 1'b1; end
    @(posedge clk);
    #1;
    for (int l = 0; l < 3; l++) out_ready[l] = 1'b0;
    @(negedge clk);
    for (int l = 0; l < 3; l++) begin
      n_vec += 2;
      if (in_ready[l] !== 1'b1) begin n_err++; $display("FAIL lane%0d release_inReady: got %b want 1", l, in_ready[l]); end
      if (out_valid[l] !== 1'b0) begin n_err++; $display("FAIL lane%0d release_outValid: got %b want 0", l, out_valid[l]); end
    end
    @(posedge clk);
    #1;

    // Reset in BUSY with colCnt=2 on the one-column lane.
    send(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b1, '0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    q0.delete();
    q1.delete();
    q2.delete();
    @(negedge clk);
    for (int l = 0; l < 3; l++) begin
      n_vec += 4;
      if (in_ready[l] !== 1'b1) begin n_err++; $display("FAIL lane%0d abort_inReady: got %b want 1", l, in_ready[l]); end
      if (out_valid[l] !== 1'b0) begin n_err++; $display("FAIL lane%0d abort_outValid: got %b want 0", l, out_valid[l]); end
      if (out_data[l] !== '0) begin n_err++; $display("FAIL lane%0d abort_outData: got %h want 0", l, out_data[l]); end
      if (busy[l] !== 1'b0) begin n_err++; $display("FAIL lane%0d abort_busy: got %b want 0", l, busy[l]); end
    end
    @(posedge clk);
    #1;
    for (int l = 0; l < 3; l++) out_ready[l] = 1'b1;
    send({4{32'h01010101}}, 1'b0, {4{32'h01010101}}, 0);
    wait_drain();

    // Soak: random blocks and modes, each followed by its round trip.
    rdy_mode = 1;
    for (int i = 0; i < 600; i++) begin
      x   = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom_range(0, 1));
      y   = mix_ref(x, inv);
      send(x, inv, y, $urandom_range(0, 2));
      send(y, ~inv, x, $urandom_range(0, 2));
    end
    wait_drain();
    rdy_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
